// File: rtl/fft8_pkg.sv
// Shared constants and the sequencer state type for the 8-point radix-2 DIT FFT control path.
package fft8_pkg;

  localparam int FFT_N          = 8;
  localparam int FFT_STAGES     = 3;
  localparam int BFLY_PER_STAGE = 4;
  localparam int ADDR_W         = 3;
  localparam int TW_IDX_W       = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fft8_wb_delay.sv
// Resettable fixed-depth delay line carrying {valid, addrA, addrB} from read issue to write-back.
module fft8_wb_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = i_clk ^ i_rst;
      assign o_data   = i_data;
    end else begin : g_line
      logic [WIDTH-1:0] r_line [DEPTH];

      // Reset clears every stage so nothing issued before reset is ever written back.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
        end else begin
          r_line[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
        end
      end

      assign o_data = r_line[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fft8_bfly_sequencer.sv
// Issues the 3x4 butterfly read addresses and twiddle indices of an 8-point DIT FFT,
// delays the write-back addresses by the butterfly latency and drains between stages.
module fft8_bfly_sequencer
  import fft8_pkg::*;
#(
  parameter int BFLY_LAT = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Start,
  input  logic                Hold,
  output logic                Rd_Valid,
  output logic [ADDR_W-1:0]   Rd_Addr_A,
  output logic [ADDR_W-1:0]   Rd_Addr_B,
  output logic [TW_IDX_W-1:0] Twiddle_Index,
  output logic                Wr_En,
  output logic [ADDR_W-1:0]   Wr_Addr_A,
  output logic [ADDR_W-1:0]   Wr_Addr_B,
  output logic [1:0]          Stage,
  output logic                Busy,
  output logic                Done
);

  localparam int         WB_W       = 1 + 2 * ADDR_W;
  localparam logic [2:0] LAST_DRAIN = 3'(BFLY_LAT > 0 ? BFLY_LAT - 1 : 0);
  localparam logic [1:0] LAST_STAGE = 2'(FFT_STAGES - 1);
  localparam logic [1:0] LAST_BFLY  = 2'(BFLY_PER_STAGE - 1);

  seq_state_t          r_state, w_stateNext;
  logic [1:0]          r_s, w_sNext;
  logic [1:0]          r_k, w_kNext;
  logic [2:0]          r_drain, w_drainNext;
  logic                w_issue;
  logic                w_idle;
  logic [ADDR_W-1:0]   w_span, w_pos, w_grp, w_addrA, w_addrB;
  logic [TW_IDX_W-1:0] w_tw;
  logic [WB_W-1:0]     w_wbData;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_k     <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_stateNext;
      r_s     <= w_sNext;
      r_k     <= w_kNext;
      r_drain <= w_drainNext;
    end
  end

  // k stays at 3 through WAIT/DONE so the read addresses keep the last issued butterfly.
  always_comb begin
    w_stateNext = r_state;
    w_sNext     = r_s;
    w_kNext     = r_k;
    w_drainNext = r_drain;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Start) begin
          w_stateNext = ISSUE;
          w_sNext     = '0;
          w_kNext     = '0;
        end
      end
      ISSUE: begin
        if (!Hold) begin
          w_issue = 1'b1;
          if (r_k == LAST_BFLY) begin
            if (BFLY_LAT > 0) begin
              w_stateNext = WAIT;
              w_drainNext = '0;
            end else if (r_s == LAST_STAGE) begin
              w_stateNext = DONE;
            end else begin
              w_sNext = r_s + 2'd1;
              w_kNext = '0;
            end
          end else begin
            w_kNext = r_k + 2'd1;
          end
        end
      end
      WAIT: begin
        w_drainNext = r_drain + 3'd1;
        if (r_drain == LAST_DRAIN) begin
          w_drainNext = '0;
          if (r_s == LAST_STAGE) begin
            w_stateNext = DONE;
          end else begin
            w_stateNext = ISSUE;
            w_sNext     = r_s + 2'd1;
            w_kNext     = '0;
          end
        end
      end
      DONE: begin
        w_stateNext = IDLE;
        w_sNext     = '0;
        w_kNext     = '0;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_span  = ADDR_W'(1) << r_s;
  assign w_pos   = {1'b0, r_k} & (w_span - 3'd1);
  assign w_grp   = {1'b0, r_k} >> r_s;
  assign w_addrA = (w_grp << (r_s + 2'd1)) + w_pos;
  assign w_addrB = w_addrA + w_span;
  assign w_tw    = TW_IDX_W'(w_pos << (2'd2 - r_s));
  assign w_idle  = (r_state == IDLE);

  // Addresses read as zero while idle so the block is quiet after reset and between transforms.
  assign Rd_Valid      = w_issue;
  assign Rd_Addr_A     = w_idle ? '0 : w_addrA;
  assign Rd_Addr_B     = w_idle ? '0 : w_addrB;
  assign Twiddle_Index = w_idle ? '0 : w_tw;
  assign Stage         = r_s;
  assign Busy          = !w_idle;
  assign Done          = (r_state == DONE);

  fft8_wb_delay #(
    .DEPTH(BFLY_LAT),
    .WIDTH(WB_W)
  ) u_wbDelay (
    .i_clk (CLK),
    .i_rst (RST),
    .i_data({w_issue, Rd_Addr_A, Rd_Addr_B}),
    .o_data(w_wbData)
  );

  assign {Wr_En, Wr_Addr_A, Wr_Addr_B} = w_wbData;

endmodule

// File: tb/tb_fft8_bfly_sequencer.sv
// Bench for fft8_bfly_sequencer: spec-derived vector table, directed corner sequences and a
// randomized run checked against a schedule-list reference model; a second instance uses BFLY_LAT=0.
module tb_fft8_bfly_sequencer;

  localparam int LAT = 2;

  logic       CLK   = 1'b0;
  logic       RST   = 1'b1;
  logic       Start = 1'b0;
  logic       Hold  = 1'b0;

  logic       rdValid2, wrEn2, busy2, done2;
  logic [2:0] rdA2, rdB2, wrA2, wrB2;
  logic [1:0] tw2, stage2;
  logic       rdValid0, wrEn0, busy0, done0;
  logic [2:0] rdA0, rdB0, wrA0, wrB0;
  logic [1:0] tw0, stage0;

  always #5 CLK = ~CLK;

  fft8_bfly_sequencer #(.BFLY_LAT(LAT)) dut2 (
    .CLK(CLK), .RST(RST), .Start(Start), .Hold(Hold),
    .Rd_Valid(rdValid2), .Rd_Addr_A(rdA2), .Rd_Addr_B(rdB2), .Twiddle_Index(tw2),
    .Wr_En(wrEn2), .Wr_Addr_A(wrA2), .Wr_Addr_B(wrB2),
    .Stage(stage2), .Busy(busy2), .Done(done2)
  );

  fft8_bfly_sequencer #(.BFLY_LAT(0)) dut0 (
    .CLK(CLK), .RST(RST), .Start(Start), .Hold(Hold),
    .Rd_Valid(rdValid0), .Rd_Addr_A(rdA0), .Rd_Addr_B(rdB0), .Twiddle_Index(tw0),
    .Wr_En(wrEn0), .Wr_Addr_A(wrA0), .Wr_Addr_B(wrB0),
    .Stage(stage0), .Busy(busy0), .Done(done0)
  );

  typedef struct { bit isIssue; bit isDone; int a; int b; int tw; int stage; } slot_t;
  typedef struct { bit v; int a; int b; } wb_t;
  typedef struct { bit start; bit rd; int a; int b; int tw; bit wr; int wa; int wb; bit busy; bit done; } vec_t;

  slot_t plan[$];
  wb_t   hist[$];
  vec_t  tbl[21];
  int    sA[12], sB[12], sT[12];
  int    total = 0, passed = 0, cyc = 0, lastDone = -1, firstRd = -1, wrSeen = 0;
  bit    checkLat0 = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
  endtask

  // Butterfly k of stage s straight from the span/pos/grp arithmetic.
  function automatic slot_t bfly(input int s, input int k);
    slot_t t;
    int span, pos;
    span      = 1 << s;
    pos       = k % span;
    t.isIssue = 1'b1;
    t.isDone  = 1'b0;
    t.stage   = s;
    t.a       = (k / span) * 2 * span + pos;
    t.b       = t.a + span;
    t.tw      = pos * 4 / span;
    return t;
  endfunction

  // A transform is a list of cycle slots: 4 issues + LAT drain slots per stage, then one done slot.
  task automatic buildPlan();
    slot_t t;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) plan.push_back(bfly(s, k));
      for (int g = 0; g < LAT; g++) begin
        t = bfly(s, 3);
        t.isIssue = 1'b0;
        plan.push_back(t);
      end
    end
    t = bfly(2, 3);
    t.isIssue = 1'b0;
    t.isDone  = 1'b1;
    plan.push_back(t);
  endtask

  task automatic modelCheck();
    slot_t f;
    wb_t   e, h;
    bit    active, expRd;
    active = (plan.size() > 0);
    f = '{1'b0, 1'b0, 0, 0, 0, 0};
    if (active) f = plan[0];
    expRd = active && f.isIssue && !Hold;
    e = '{1'b0, 0, 0};
    if (hist.size() >= LAT) e = hist[hist.size() - LAT];
    checkOutput("Rd_Valid", rdValid2, expRd);
    checkOutput("Wr_En", wrEn2, e.v);
    if (e.v) begin
      checkOutput("Wr_Addr_A", wrA2, e.a);
      checkOutput("Wr_Addr_B", wrB2, e.b);
    end
    checkOutput("Busy", busy2, active);
    checkOutput("Done", done2, active && f.isDone);
    checkOutput("Stage", stage2, f.stage);
    if (active) begin
      checkOutput("Rd_Addr_A", rdA2, f.a);
      checkOutput("Rd_Addr_B", rdB2, f.b);
      checkOutput("Twiddle_Index", tw2, f.tw);
    end
    if (done2) lastDone = cyc;
    if (rdValid2 && firstRd < 0) firstRd = cyc;
    if (wrEn2) wrSeen++;
    h = '{expRd, f.a, f.b};
    hist.push_back(h);
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic modelAdvance();
    if (RST) begin
      plan.delete();
      hist.delete();
    end else if (plan.size() == 0) begin
      if (Start) buildPlan();
    end else if (!(plan[0].isIssue && Hold)) begin
      void'(plan.pop_front());
    end
  endtask

  task automatic applyStimulus();
    bit expRd0;
    @(negedge CLK);
    modelCheck();
    if (checkLat0) begin
      expRd0 = (cyc >= 1 && cyc <= 12);
      checkOutput("L0 Rd_Valid", rdValid0, expRd0);
      checkOutput("L0 Wr_En", wrEn0, expRd0);
      checkOutput("L0 Done", done0, cyc == 13);
      checkOutput("L0 Busy", busy0, cyc >= 1 && cyc <= 13);
      if (expRd0) begin
        checkOutput("L0 Rd_Addr_A", rdA0, sA[cyc-1]);
        checkOutput("L0 Rd_Addr_B", rdB0, sB[cyc-1]);
        checkOutput("L0 Twiddle", tw0, sT[cyc-1]);
        checkOutput("L0 Wr_Addr_A", wrA0, sA[cyc-1]);
        checkOutput("L0 Wr_Addr_B", wrB0, sB[cyc-1]);
      end
    end
    @(posedge CLK);
    modelAdvance();
    cyc++;
    #1;
  endtask

  task automatic applyReset();
    RST = 1'b1; Start = 1'b0; Hold = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    checkOutput("Reset Rd_Valid", rdValid2, 0);
    checkOutput("Reset Rd_Addr_A", rdA2, 0);
    checkOutput("Reset Rd_Addr_B", rdB2, 0);
    checkOutput("Reset Twiddle", tw2, 0);
    checkOutput("Reset Wr_En", wrEn2, 0);
    checkOutput("Reset Wr_Addr_A", wrA2, 0);
    checkOutput("Reset Wr_Addr_B", wrB2, 0);
    checkOutput("Reset Stage", stage2, 0);
    checkOutput("Reset Busy", busy2, 0);
    checkOutput("Reset Done", done2, 0);
    checkOutput("Reset L0 Busy", busy0, 0);
    checkOutput("Reset L0 Rd_Addr_B", rdB0, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    plan.delete();
    hist.delete();
  endtask

  task automatic startRun();
    Start = 1'b1; cyc = 0; lastDone = -1; firstRd = -1;
    applyStimulus();
    Start = 1'b0;
  endtask

  function automatic int issueIdx(input int c);
    if (c >= 1 && c <= 4) return c - 1;
    if (c >= 7 && c <= 10) return c - 3;
    if (c >= 13 && c <= 16) return c - 5;
    return -1;
  endfunction

  initial begin
    int ri, wi;
    sA = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    sB = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    sT = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    for (int c = 0; c < 21; c++) begin
      ri = issueIdx(c);
      wi = issueIdx(c - 2);
      tbl[c].start = (c == 0);
      tbl[c].rd    = (ri >= 0);
      tbl[c].a     = (ri >= 0) ? sA[ri] : 0;
      tbl[c].b     = (ri >= 0) ? sB[ri] : 0;
      tbl[c].tw    = (ri >= 0) ? sT[ri] : 0;
      tbl[c].wr    = (wi >= 0);
      tbl[c].wa    = (wi >= 0) ? sA[wi] : 0;
      tbl[c].wb    = (wi >= 0) ? sB[wi] : 0;
      tbl[c].busy  = (c >= 1 && c <= 19);
      tbl[c].done  = (c == 19);
    end

    applyReset();
    for (int c = 0; c < 21; c++) begin
      Start = tbl[c].start; cyc = c;
      @(negedge CLK);
      checkOutput("Tbl Rd_Valid", rdValid2, tbl[c].rd);
      if (tbl[c].rd) begin
        checkOutput("Tbl Rd_Addr_A", rdA2, tbl[c].a);
        checkOutput("Tbl Rd_Addr_B", rdB2, tbl[c].b);
        checkOutput("Tbl Twiddle", tw2, tbl[c].tw);
      end
      checkOutput("Tbl Wr_En", wrEn2, tbl[c].wr);
      if (tbl[c].wr) begin
        checkOutput("Tbl Wr_Addr_A", wrA2, tbl[c].wa);
        checkOutput("Tbl Wr_Addr_B", wrB2, tbl[c].wb);
      end
      checkOutput("Tbl Busy", busy2, tbl[c].busy);
      checkOutput("Tbl Done", done2, tbl[c].done);
      @(posedge CLK); #1;
    end
    Start = 1'b0;

    // Hold over stage 1, butterfly 2 for three cycles pushes Done out by three.
    applyReset();
    startRun();
    while (cyc <= 24) begin
      Hold = (cyc >= 9 && cyc <= 11);
      applyStimulus();
    end
    Hold = 1'b0;
    checkOutput("Hold DoneCycle", lastDone, 22);

    // Start while busy (cycle 8, and together with Done) is ignored; Start in IDLE restarts.
    applyReset();
    startRun();
    while (cyc <= 40) begin
      Start = (cyc == 8 || cyc == 19 || cyc == 20);
      if (cyc == 20) begin
        checkOutput("First DoneCycle", lastDone, 19);
        firstRd = -1;
      end
      applyStimulus();
    end
    Start = 1'b0;
    checkOutput("Restart FirstRd", firstRd, 21);
    checkOutput("Restart DoneCycle", lastDone, 39);

    // Reset in the middle of stage 1 kills all pending write-backs.
    applyReset();
    startRun();
    while (cyc <= 20) begin
      RST = (cyc == 9);
      if (cyc == 10) wrSeen = 0;
      applyStimulus();
    end
    RST = 1'b0;
    checkOutput("Wr_En after reset", wrSeen, 0);
    startRun();
    while (cyc <= 20) applyStimulus();
    checkOutput("Post-reset DoneCycle", lastDone, 19);

    // Zero-latency instance: back-to-back issue with combinational write-back.
    applyReset();
    checkLat0 = 1'b1;
    startRun();
    while (cyc <= 15) applyStimulus();
    checkLat0 = 1'b0;

    // Randomized Start/Hold/reset traffic against the schedule model.
    applyReset();
    for (int n = 0; n < 600; n++) begin
      Start = ($urandom_range(0, 5) == 0);
      Hold  = ($urandom_range(0, 2) == 0);
      RST   = ($urandom_range(0, 149) == 0);
      applyStimulus();
    end
    RST = 1'b0; Start = 1'b0; Hold = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
